// File: rtl/neuron_core_tm_if.sv
// neuron_core_tm_if: event, sweep, programming and spike-output signals of the neuron core
interface neuron_core_tm_if #(
  parameter int M = 8,
  parameter int W = 8
);
  logic           EV_VALID;
  logic           EV_READY;
  logic [M-1:0]   EV_ADDR;
  logic [3:0]     EV_WEIGHT;
  logic           TREF_START;
  logic           TREF_BUSY;
  logic           PROG_VALID;
  logic [M-1:0]   PROG_ADDR;
  logic [2*W+7:0] PROG_DATA;
  logic           SPK_VALID;
  logic           SPK_READY;
  logic [M-1:0]   SPK_ADDR;
  logic [W-1:0]   STATE_MON;
  modport master (
    output EV_VALID, EV_ADDR, EV_WEIGHT, TREF_START, PROG_VALID, PROG_ADDR, PROG_DATA, SPK_READY,
    input  EV_READY, TREF_BUSY, SPK_VALID, SPK_ADDR, STATE_MON
  );
  modport slave (
    input  EV_VALID, EV_ADDR, EV_WEIGHT, TREF_START, PROG_VALID, PROG_ADDR, PROG_DATA, SPK_READY,
    output EV_READY, TREF_BUSY, SPK_VALID, SPK_ADDR, STATE_MON
  );
endinterface

// File: rtl/neuron_core_tm.sv
// neuron_core_tm: time-multiplexed LIF neuron core with forwarded RMW pipeline, leak sweep and spike FIFO
module neuron_core_tm #(
  parameter int N = 256,
  parameter int M = 8,
  parameter int W = 8,
  parameter int SPK_DEPTH = 4
) (
  input logic CLK,
  input logic RST_sync,
  neuron_core_tm_if.slave bus
);
  localparam int DW = 2*W+8;
  localparam int PW = $clog2(SPK_DEPTH);
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;
  state_t state, state_n;
  logic [M-1:0] cnt, cnt_n;
  logic [DW-1:0] mem [N];
  logic [DW-1:0] rd_data, fwd_data, s1_word, s1_out, pend_data, wr_data;
  logic [M-1:0] s1_addr, pend_addr, wr_addr, issue_addr, last_addr;
  logic [M-1:0] fifo [SPK_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0] count;
  logic [W-1:0] cur, thr, mag, upd, mon;
  logic [W+6:0] cw, lk, diff;
  logic [W:0] sum;
  logic [6:0] leak;
  logic [2:0] s1_mag;
  logic s1_neg, s1_valid, s1_ev, fwd, pend_v, dis, spike;
  logic prog, credit, sweep_go, ev_go, issue, s1_we, we, push, pop;
  always_comb begin
    prog = bus.PROG_VALID;
    credit = int'(count) + int'(s1_valid && s1_ev) < SPK_DEPTH;
    bus.TREF_BUSY = state != IDLE;
    bus.EV_READY = !RST_sync && !prog && state == IDLE && credit;
    bus.SPK_VALID = count != 0;
    bus.SPK_ADDR = count != 0 ? fifo[rp] : last_addr;
    bus.STATE_MON = mon;
    sweep_go = state == SWEEP && !prog && credit;
    ev_go = bus.EV_VALID && bus.EV_READY;
    issue = sweep_go || ev_go;
    issue_addr = sweep_go ? cnt : bus.EV_ADDR;
    state_n = state == IDLE ? (bus.TREF_START ? SWEEP : IDLE) :
              state == SWEEP ? (sweep_go && cnt == M'(N-1) ? DRAIN : SWEEP) : IDLE;
    cnt_n = state == IDLE ? '0 : cnt + M'(sweep_go);
  end
  // S1: the forwarded word replaces the stale read when the previous cycle wrote this address
  always_comb begin
    s1_word = fwd ? fwd_data : rd_data;
    cur = s1_word[W-1:0];
    thr = s1_word[2*W-1:W];
    leak = s1_word[2*W+6:2*W];
    dis = s1_word[2*W+7];
    mag = W'(s1_mag);
    sum = {1'b0, cur} + (W+1)'(s1_mag);
    cw = (W+7)'(cur);
    lk = (W+7)'(leak);
    diff = cw - lk;
    upd = !s1_ev ? (cw > lk ? diff[W-1:0] : '0) :
          s1_neg ? (cur < mag ? '0 : cur - mag) : (sum[W] ? '1 : sum[W-1:0]);
    spike = s1_ev && !dis && thr != '0 && upd >= thr;
    s1_out = dis ? s1_word : {s1_word[DW-1:W], spike ? {W{1'b0}} : upd};
    s1_we = s1_valid && !(prog && bus.PROG_ADDR == s1_addr);
    we = prog || s1_we || pend_v;
    wr_addr = prog ? bus.PROG_ADDR : s1_we ? s1_addr : pend_addr;
    wr_data = prog ? bus.PROG_DATA : s1_we ? s1_out : pend_data;
    push = s1_valid && spike;
    pop = bus.SPK_READY && count != 0;
  end
  always_ff @(posedge CLK) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[issue_addr];
    fwd_data <= wr_data;
    if (push) fifo[wp] <= s1_addr;
  end
  // A PROG colliding with a write-back to another address parks that write until the port is free
  always_ff @(posedge CLK) begin
    if (RST_sync) begin
      state <= IDLE;
      cnt <= '0;
      s1_valid <= 1'b0;
      fwd <= 1'b0;
      pend_v <= 1'b0;
      wp <= '0;
      rp <= '0;
      count <= '0;
      last_addr <= '0;
      mon <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      s1_valid <= issue;
      s1_ev <= ev_go;
      s1_addr <= issue_addr;
      s1_mag <= bus.EV_WEIGHT[2:0];
      s1_neg <= bus.EV_WEIGHT[3];
      fwd <= we && wr_addr == issue_addr;
      pend_v <= prog ? (s1_we || (pend_v && bus.PROG_ADDR != pend_addr)) : (pend_v && s1_we);
      if (prog && s1_we) begin
        pend_addr <= s1_addr;
        pend_data <= s1_out;
      end
      wp <= wp + PW'(push);
      rp <= rp + PW'(pop);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      if (pop) last_addr <= fifo[rp];
      if (we) mon <= wr_data[W-1:0];
    end
  end
endmodule

// File: tb/tb_neuron_core_tm.sv
// tb_neuron_core_tm: directed scoreboard bench for neuron_core_tm
module tb_neuron_core_tm;
  typedef struct { int due; int val; } mon_t;
  logic CLK = 1'b0;
  logic RST_sync = 1'b1;
  int errors = 0;
  int checks = 0;
  int cyc_n = 0;
  mon_t mon_q[$];
  int spk_q[$];
  mon_t mh;
  neuron_core_tm_if #(.M(8), .W(8)) bus();
  neuron_core_tm #(.N(256), .M(8), .W(8), .SPK_DEPTH(4)) dut (
    .CLK(CLK),
    .RST_sync(RST_sync),
    .bus(bus.slave)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc_n <= cyc_n + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  always @(negedge CLK) begin
    #2;
    if (bus.SPK_VALID && bus.SPK_READY) begin
      if (spk_q.size() == 0) chk("spk_extra", spk_q.size(), 1);
      else chk("spk_addr", bus.SPK_ADDR, spk_q.pop_front());
    end
    if (mon_q.size() != 0 && mon_q[0].due <= cyc_n) begin
      mh = mon_q.pop_front();
      chk("state_mon", bus.STATE_MON, mh.val);
    end
  end
  task automatic prog(input int a, input int dis, input int leak, input int thr, input int m);
    bus.PROG_ADDR = a[7:0];
    bus.PROG_DATA = {dis[0], leak[6:0], thr[7:0], m[7:0]};
    bus.PROG_VALID = 1'b1;
    mon_q.push_back('{cyc_n + 1, m});
    @(negedge CLK);
    bus.PROG_VALID = 1'b0;
  endtask
  task automatic ev(input int a, input logic [3:0] w, input int m, input bit spk);
    int t = 0;
    bus.EV_ADDR = a[7:0];
    bus.EV_WEIGHT = w;
    bus.EV_VALID = 1'b1;
    #1;
    while (!bus.EV_READY && t < 20) begin
      @(negedge CLK);
      #1;
      t++;
    end
    chk("ev_ready", bus.EV_READY, 1);
    mon_q.push_back('{cyc_n + 2, m});
    if (spk) spk_q.push_back(a);
    @(negedge CLK);
    bus.EV_VALID = 1'b0;
    repeat (2) @(negedge CLK);
  endtask
  task automatic rd(input int a, input int m);
    bus.EV_ADDR = a[7:0];
    bus.EV_WEIGHT = 4'd0;
    bus.EV_VALID = 1'b1;
    #1;
    chk("rd_ready", bus.EV_READY, 1);
    mon_q.push_back('{cyc_n + 2, m});
    @(negedge CLK);
  endtask
  task automatic rd_end();
    bus.EV_VALID = 1'b0;
    repeat (3) @(negedge CLK);
  endtask
  task automatic prog_all();
    for (int i = 0; i < 256; i++) prog(i, 0, 2, 0, 5);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int busy_n, rdy_bad, acc;
    bus.EV_VALID = 1'b0;
    bus.EV_ADDR = '0;
    bus.EV_WEIGHT = '0;
    bus.TREF_START = 1'b0;
    bus.PROG_VALID = 1'b0;
    bus.PROG_ADDR = '0;
    bus.PROG_DATA = '0;
    bus.SPK_READY = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_ev_ready", bus.EV_READY, 0);
    chk("rst_tref_busy", bus.TREF_BUSY, 0);
    chk("rst_spk_valid", bus.SPK_VALID, 0);
    chk("rst_spk_addr", bus.SPK_ADDR, 0);
    chk("rst_state_mon", bus.STATE_MON, 0);
    RST_sync = 1'b0;
    @(negedge CLK);
    // back-to-back events to one neuron accumulate through forwarding
    prog(5, 0, 2, 10, 0);
    for (int i = 0; i < 3; i++) begin
      bus.EV_ADDR = 8'd5;
      bus.EV_WEIGHT = 4'd4;
      bus.EV_VALID = 1'b1;
      #1;
      chk("b2b_ready", bus.EV_READY, 1);
      mon_q.push_back('{cyc_n + 2, i == 2 ? 0 : 4 * (i + 1)});
      if (i == 2) spk_q.push_back(5);
      @(negedge CLK);
    end
    bus.EV_VALID = 1'b0;
    repeat (4) @(negedge CLK);
    #1;
    chk("spk_empty_after_pop", bus.SPK_VALID, 0);
    chk("spk_addr_hold", bus.SPK_ADDR, 5);
    // inhibitory clamp at zero and excitatory saturation
    prog(7, 0, 0, 0, 3);
    ev(7, 4'b1101, 0, 0);
    prog(7, 0, 0, 0, 250);
    ev(7, 4'b0111, 255, 0);
    #1;
    chk("no_spike_thr0", bus.SPK_VALID, 0);
    // full leak sweep; a second start mid-sweep is ignored
    prog_all();
    bus.TREF_START = 1'b1;
    @(negedge CLK);
    bus.TREF_START = 1'b0;
    busy_n = 0;
    rdy_bad = 0;
    for (int t = 0; t < 400; t++) begin
      #1;
      if (!bus.TREF_BUSY) break;
      busy_n++;
      if (bus.EV_READY) rdy_bad++;
      bus.TREF_START = busy_n == 100;
      @(negedge CLK);
    end
    bus.TREF_START = 1'b0;
    chk("sweep_busy_cycles", busy_n, 257);
    chk("sweep_ev_ready_low", rdy_bad, 0);
    for (int i = 0; i < 256; i++) rd(i, 3);
    rd_end();
    // spike FIFO backpressure and in-order release
    for (int i = 10; i < 16; i++) prog(i, 0, 0, 1, 0);
    bus.SPK_READY = 1'b0;
    bus.EV_WEIGHT = 4'd1;
    acc = 0;
    for (int t = 0; t < 10; t++) begin
      bus.EV_ADDR = 8'(10 + acc);
      bus.EV_VALID = acc < 6;
      #1;
      if (bus.EV_VALID && bus.EV_READY) begin
        spk_q.push_back(10 + acc);
        mon_q.push_back('{cyc_n + 2, 0});
        acc++;
      end
      @(negedge CLK);
    end
    #1;
    chk("fifo_accepted", acc, 4);
    chk("fifo_full_ready", bus.EV_READY, 0);
    chk("fifo_full_valid", bus.SPK_VALID, 1);
    chk("fifo_head", bus.SPK_ADDR, 10);
    bus.SPK_READY = 1'b1;
    for (int t = 0; t < 40 && acc < 6; t++) begin
      bus.EV_ADDR = 8'(10 + acc);
      bus.EV_VALID = 1'b1;
      #1;
      if (bus.EV_READY) begin
        spk_q.push_back(10 + acc);
        mon_q.push_back('{cyc_n + 2, 0});
        acc++;
      end
      @(negedge CLK);
    end
    bus.EV_VALID = 1'b0;
    for (int t = 0; t < 20 && spk_q.size() != 0; t++) @(negedge CLK);
    repeat (2) @(negedge CLK);
    chk("fifo_all_accepted", acc, 6);
    chk("fifo_drained", spk_q.size(), 0);
    // PROG during a sweep stalls it one cycle and parks the colliding write-back
    prog_all();
    bus.TREF_START = 1'b1;
    @(negedge CLK);
    bus.TREF_START = 1'b0;
    busy_n = 0;
    for (int t = 0; t < 400; t++) begin
      #1;
      if (!bus.TREF_BUSY) break;
      busy_n++;
      if (busy_n == 101) begin
        bus.PROG_ADDR = 8'd50;
        bus.PROG_DATA = {1'b0, 7'd2, 8'd0, 8'd77};
        bus.PROG_VALID = 1'b1;
        mon_q.push_back('{cyc_n + 1, 77});
        mon_q.push_back('{cyc_n + 2, 3});
      end else bus.PROG_VALID = 1'b0;
      @(negedge CLK);
    end
    bus.PROG_VALID = 1'b0;
    chk("stall_busy_cycles", busy_n, 258);
    rd(0, 3);
    rd(50, 77);
    rd(99, 3);
    rd(100, 3);
    rd(255, 3);
    rd_end();
    // reset mid-sweep aborts it and empties the FIFO
    prog_all();
    prog(200, 0, 0, 1, 0);
    bus.SPK_READY = 1'b0;
    ev(200, 4'd1, 0, 1);
    #1;
    chk("pre_rst_spk_valid", bus.SPK_VALID, 1);
    bus.TREF_START = 1'b1;
    @(negedge CLK);
    bus.TREF_START = 1'b0;
    busy_n = 0;
    for (int t = 0; t < 400; t++) begin
      #1;
      if (!bus.TREF_BUSY) break;
      busy_n++;
      if (busy_n == 51) begin
        RST_sync = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    @(negedge CLK);
    #1;
    chk("rst_sweep_reached", busy_n, 51);
    chk("rst_mid_tref_busy", bus.TREF_BUSY, 0);
    chk("rst_mid_spk_valid", bus.SPK_VALID, 0);
    chk("rst_mid_ev_ready", bus.EV_READY, 0);
    spk_q.delete();
    RST_sync = 1'b0;
    bus.SPK_READY = 1'b1;
    rd(0, 3);
    rd(49, 3);
    rd(50, 5);
    rd(51, 5);
    rd(128, 5);
    rd_end();
    chk("mon_q_drained", mon_q.size(), 0);
    chk("spk_q_drained", spk_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
